// File: rtl/seq_pkg.sv
// Shared constants for the ASCII bit-sequence feeder and its bench model.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_STEP,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    localparam logic [7:0]  ASCII_E          = 8'h45;
    localparam int unsigned STEP_DIV_DEFAULT = 25_000_000;
    localparam int unsigned DIV_W_DEFAULT    = 26;

    // Bit pattern recognised by the downstream detector, oldest bit first.
    localparam logic [7:0]  DET_PATTERN      = 8'b0100_0101;

endpackage

// File: rtl/seq_step_timer.sv
// Step-rate divider: counts while start is high and pulses done on the
// STEP_DIV-th cycle, then wraps to zero. clear forces the count back to zero.
module seq_step_timer #(
    parameter int unsigned STEP_DIV = 25_000_000,
    parameter int unsigned DIV_W    = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic done
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(STEP_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    // Next count and terminal-count pulse.
    always_comb begin
        // NOTE: every variable gets a default first so no branch can leave it
        // unassigned, which would otherwise infer a latch.
        div_cnt_d = div_cnt_q;
        done      = 1'b0;
        if (clear) begin
            div_cnt_d = '0;
        end else if (start) begin
            if (div_cnt_q == LAST) begin
                div_cnt_d = '0;
                done      = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/ascii_seq_feeder.sv
// Serialises accepted ASCII bytes MSB-first into a bit-sequence detector,
// pacing each bit with a step strobe and tallying bytes that produced a hit.
module ascii_seq_feeder
    import seq_pkg::*;
#(
    parameter int unsigned STEP_DIV = STEP_DIV_DEFAULT,
    parameter int unsigned DIV_W    = DIV_W_DEFAULT,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             clr_req,
    output logic             det_bit,
    output logic             det_step,
    output logic             det_clr,
    input  logic             det_hit,
    output logic             busy,
    output logic             byte_done,
    output logic             last_hit,
    output logic [CNT_W-1:0] hit_count
);

    state_e           state_q,     state_d;
    logic [7:0]       shreg_q,     shreg_d;
    logic [2:0]       bit_idx_q,   bit_idx_d;
    logic             hit_seen_q,  hit_seen_d;
    logic             det_bit_q,   det_bit_d;
    logic             last_hit_q,  last_hit_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic             timer_done;

    // The divider runs only in WAIT and is held at zero everywhere else,
    // so every bit starts from a fresh count.
    seq_step_timer #(
        .STEP_DIV (STEP_DIV),
        .DIV_W    (DIV_W)
    ) u_timer (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .start (state_q == ST_WAIT),
        .clear (state_q != ST_WAIT),
        .done  (timer_done)
    );

    // Next-state logic and Moore outputs of the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_idx_d   = bit_idx_q;
        hit_seen_d  = hit_seen_q;
        det_bit_d   = det_bit_q;
        last_hit_d  = last_hit_q;
        hit_count_d = hit_count_q;
        in_ready    = 1'b0;
        busy        = 1'b1;
        det_step    = 1'b0;
        det_clr     = 1'b0;
        byte_done   = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                det_clr = 1'b1;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (clr_req) begin
                    hit_count_d = '0;
                    last_hit_d  = 1'b0;
                    state_d     = ST_INIT;
                end else if (in_valid) begin
                    shreg_d    = in_data;
                    bit_idx_d  = 3'd7;
                    hit_seen_d = 1'b0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // det_bit is loaded on the edge into STEP so it is already
                // stable while the step strobe is high.
                if (timer_done) begin
                    det_bit_d = shreg_q[7];
                    state_d   = ST_STEP;
                end
            end
            ST_STEP: begin
                det_step = 1'b1;
                shreg_d  = {shreg_q[6:0], 1'b0};
                state_d  = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (det_hit) begin
                    hit_seen_d = 1'b1;
                end
                if (bit_idx_q == 3'd0) begin
                    state_d = ST_DONE;
                end else begin
                    bit_idx_d = bit_idx_q - 3'd1;
                    state_d   = ST_WAIT;
                end
            end
            ST_DONE: begin
                byte_done  = 1'b1;
                last_hit_d = hit_seen_q;
                if (hit_seen_q && (hit_count_q != '1)) begin
                    hit_count_d = hit_count_q + 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State and datapath registers; RESET discards any in-flight byte.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q     <= ST_INIT;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            hit_seen_q  <= 1'b0;
            det_bit_q   <= 1'b0;
            last_hit_q  <= 1'b0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            hit_seen_q  <= hit_seen_d;
            det_bit_q   <= det_bit_d;
            last_hit_q  <= last_hit_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign det_bit   = det_bit_q;
    assign last_hit  = last_hit_q;
    assign hit_count = hit_count_q;

endmodule

// File: tb/tb_ascii_seq_feeder.sv
// Scoreboard bench: two feeders (8-bit and 2-bit hit counters) share one
// stimulus stream, each driving its own reference "01000101" detector.
module tb_ascii_seq_feeder;
    import seq_pkg::*;

    localparam int unsigned STEP_DIV = 1;
    localparam int          BIT_CYC  = STEP_DIV + 2;
    localparam int          BYTE_LAT = 1 + 8 * BIT_CYC;

    typedef struct {
        logic       hit;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
        int         acc;
    } exp_t;

    logic       CLOCK_50, RESET, in_valid, clr_req;
    logic [7:0] in_data;

    logic       in_ready_a, det_bit_a, det_step_a, det_clr_a, det_hit_a;
    logic       busy_a, byte_done_a, last_hit_a;
    logic [7:0] hit_count_a;
    logic       in_ready_b, det_bit_b, det_step_b, det_clr_b, det_hit_b;
    logic       busy_b, byte_done_b, last_hit_b;
    logic [1:0] hit_count_b;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_done_cyc = -100;
    int   last_step_cyc = 0;

    logic bitq[$];
    exp_t resq[$];
    exp_t pend_e;
    logic pend = 1'b0;

    logic [7:0] m_hist = '0;
    int         m_cnt  = 0;
    logic [7:0] e_cnt8 = '0;
    logic [1:0] e_cnt2 = '0;

    logic [7:0] d_hist [2];
    int         d_cnt  [2];

    ascii_seq_feeder #(.STEP_DIV(STEP_DIV), .DIV_W(2), .CNT_W(8)) dut_a (
        .CLOCK_50 (CLOCK_50), .RESET (RESET),
        .in_valid (in_valid), .in_data (in_data), .in_ready (in_ready_a),
        .clr_req  (clr_req),
        .det_bit  (det_bit_a), .det_step (det_step_a), .det_clr (det_clr_a),
        .det_hit  (det_hit_a), .busy (busy_a), .byte_done (byte_done_a),
        .last_hit (last_hit_a), .hit_count (hit_count_a)
    );

    ascii_seq_feeder #(.STEP_DIV(STEP_DIV), .DIV_W(2), .CNT_W(2)) dut_b (
        .CLOCK_50 (CLOCK_50), .RESET (RESET),
        .in_valid (in_valid), .in_data (in_data), .in_ready (in_ready_b),
        .clr_req  (clr_req),
        .det_bit  (det_bit_b), .det_step (det_step_b), .det_clr (det_clr_b),
        .det_hit  (det_hit_b), .busy (busy_b), .byte_done (byte_done_b),
        .last_hit (last_hit_b), .hit_count (hit_count_b)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Reference detectors: last eight stepped bits, valid once eight are seen.
    always @(posedge CLOCK_50) begin
        if (RESET || det_clr_a) begin
            d_hist[0] <= '0;
            d_cnt[0]  <= 0;
        end else if (det_step_a) begin
            d_hist[0] <= {d_hist[0][6:0], det_bit_a};
            d_cnt[0]  <= (d_cnt[0] < 8) ? d_cnt[0] + 1 : 8;
        end
        if (RESET || det_clr_b) begin
            d_hist[1] <= '0;
            d_cnt[1]  <= 0;
        end else if (det_step_b) begin
            d_hist[1] <= {d_hist[1][6:0], det_bit_b};
            d_cnt[1]  <= (d_cnt[1] < 8) ? d_cnt[1] + 1 : 8;
        end
    end

    assign det_hit_a = (d_cnt[0] == 8) && (d_hist[0] == DET_PATTERN);
    assign det_hit_b = (d_cnt[1] == 8) && (d_hist[1] == DET_PATTERN);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic flush_model();
        bitq.delete();
        resq.delete();
        pend   = 1'b0;
        m_hist = '0;
        m_cnt  = 0;
        e_cnt8 = '0;
        e_cnt2 = '0;
    endtask

    // Predict the bit stream and the per-byte outcome of an accepted byte.
    task automatic push_expect(input logic [7:0] b, input int acc);
        exp_t e;
        logic hit;
        hit = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            bitq.push_back(b[i]);
            m_hist = {m_hist[6:0], b[i]};
            if (m_cnt < 8) m_cnt++;
            if (m_cnt == 8 && m_hist == DET_PATTERN) hit = 1'b1;
        end
        if (hit && e_cnt8 != 8'hFF) e_cnt8 = e_cnt8 + 8'd1;
        if (hit && e_cnt2 != 2'b11) e_cnt2 = e_cnt2 + 2'd1;
        e.hit  = hit;
        e.cnt8 = e_cnt8;
        e.cnt2 = e_cnt2;
        e.acc  = acc;
        resq.push_back(e);
    endtask

    // Offer n bytes with in_valid held high throughout; returns at the start
    // of the cycle after the last acceptance.
    task automatic send_bytes(input logic [7:0] d [8], input int n, input bit b2b);
        int t_acc;
        int waited;
        for (int k = 0; k < n; k++) begin
            in_data  = d[k];
            in_valid = 1'b1;
            waited   = 0;
            @(negedge CLOCK_50);
            while (!in_ready_a && waited < 200) begin
                @(negedge CLOCK_50);
                waited++;
            end
            if (!in_ready_a) begin
                check("accept_timeout", in_ready_a, 1'b1);
                in_valid = 1'b0;
                return;
            end
            t_acc = cyc;
            if (b2b && k > 0) check("b2b_accept_cycle", t_acc, last_done_cyc + 1);
            @(posedge CLOCK_50);
            push_expect(d[k], t_acc);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while (resq.size() != 0 && waited < 300) begin
            @(posedge CLOCK_50);
            waited++;
        end
        if (resq.size() != 0) begin
            check("byte_timeout", resq.size(), 0);
            flush_model();
        end
        #1;
    endtask

    // Hold RESET, then expect one INIT cycle with det_clr and a clean IDLE.
    task automatic do_reset(input int n);
        RESET    = 1'b1;
        in_valid = 1'b0;
        clr_req  = 1'b0;
        repeat (n) @(posedge CLOCK_50);
        #1 RESET = 1'b0;
        flush_model();
        @(negedge CLOCK_50);
        check("rst_det_clr_a", det_clr_a, 1'b1);
        check("rst_det_clr_b", det_clr_b, 1'b1);
        check("rst_in_ready", in_ready_a, 1'b0);
        check("rst_det_bit", det_bit_a, 1'b0);
        @(negedge CLOCK_50);
        check("idle_in_ready_a", in_ready_a, 1'b1);
        check("idle_in_ready_b", in_ready_b, 1'b1);
        check("idle_det_clr", det_clr_a, 1'b0);
        check("idle_busy", busy_a, 1'b0);
        check("idle_hit_count_a", hit_count_a, 0);
        check("idle_hit_count_b", hit_count_b, 0);
        check("idle_last_hit", last_hit_a, 1'b0);
        @(posedge CLOCK_50);
        #1;
    endtask

    // Output monitor: bit stream, step spacing, byte results, handshake.
    always @(negedge CLOCK_50) begin
        if (pend) begin
            check("last_hit_a", last_hit_a, pend_e.hit);
            check("last_hit_b", last_hit_b, pend_e.hit);
            check("hit_count_a", hit_count_a, pend_e.cnt8);
            check("hit_count_b", hit_count_b, pend_e.cnt2);
            pend = 1'b0;
        end
        if (det_step_a || det_clr_a) check("step_clr_excl", det_step_a & det_clr_a, 1'b0);
        if (resq.size() != 0) begin
            check("in_ready_busy_a", in_ready_a, 1'b0);
            check("in_ready_busy_b", in_ready_b, 1'b0);
        end
        if (det_step_a) begin
            if (bitq.size() == 0) begin
                check("step_expected", det_step_a, 1'b0);
            end else begin
                if (bitq.size() % 8 != 0) check("step_spacing", cyc - last_step_cyc, BIT_CYC);
                check("det_bit_a", det_bit_a, bitq[0]);
                check("det_bit_b", det_bit_b, bitq[0]);
                check("det_step_b", det_step_b, 1'b1);
                void'(bitq.pop_front());
            end
            last_step_cyc = cyc;
        end
        if (byte_done_a) begin
            if (resq.size() == 0) begin
                check("byte_done_expected", byte_done_a, 1'b0);
            end else begin
                pend_e = resq.pop_front();
                pend   = 1'b1;
                check("byte_done_b", byte_done_b, 1'b1);
                check("done_cycle", cyc, pend_e.acc + BYTE_LAT);
            end
            last_done_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d [8];
        RESET    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        clr_req  = 1'b0;
        for (int k = 0; k < 8; k++) d[k] = ASCII_E;

        // Single 'E' after reset: full pattern, one hit.
        do_reset(3);
        send_bytes(d, 1, 1'b0);
        wait_idle();

        // 'A' never completes the pattern; clr_req/in_valid mid-byte ignored.
        do_reset(2);
        d[0] = 8'h41;
        send_bytes(d, 1, 1'b0);
        repeat (5) @(posedge CLOCK_50);
        #1;
        clr_req  = 1'b1;
        in_valid = 1'b1;
        in_data  = ASCII_E;
        @(posedge CLOCK_50);
        #1;
        clr_req  = 1'b0;
        in_valid = 1'b0;
        wait_idle();

        // Five back-to-back 'E's: 8-bit counter 1..5, 2-bit saturates at 3.
        do_reset(1);
        d[0] = ASCII_E;
        send_bytes(d, 5, 1'b1);
        wait_idle();

        // RESET during the WAIT of the fifth bit discards the byte.
        do_reset(1);
        send_bytes(d, 1, 1'b0);
        wait_idle();
        send_bytes(d, 1, 1'b0);
        repeat (12) @(posedge CLOCK_50);
        #1 RESET = 1'b1;
        @(posedge CLOCK_50);
        #1 RESET = 1'b0;
        flush_model();
        @(negedge CLOCK_50);
        check("abort_det_clr", det_clr_a, 1'b1);
        check("abort_in_ready", in_ready_a, 1'b0);
        check("abort_det_step", det_step_a, 1'b0);
        @(negedge CLOCK_50);
        check("abort_idle", in_ready_a, 1'b1);
        check("abort_hit_count_a", hit_count_a, 0);
        check("abort_hit_count_b", hit_count_b, 0);
        check("abort_last_hit", last_hit_a, 1'b0);
        @(posedge CLOCK_50);
        #1;
        send_bytes(d, 1, 1'b0);
        wait_idle();

        // clr_req wins over in_valid in IDLE.
        send_bytes(d, 1, 1'b0);
        wait_idle();
        @(negedge CLOCK_50);
        @(posedge CLOCK_50);
        #1;
        clr_req  = 1'b1;
        in_valid = 1'b1;
        in_data  = ASCII_E;
        @(posedge CLOCK_50);
        #1;
        clr_req  = 1'b0;
        in_valid = 1'b0;
        flush_model();
        @(negedge CLOCK_50);
        check("clr_det_clr", det_clr_a, 1'b1);
        check("clr_in_ready", in_ready_a, 1'b0);
        @(negedge CLOCK_50);
        check("clr_idle", in_ready_a, 1'b1);
        check("clr_busy", busy_a, 1'b0);
        check("clr_hit_count_a", hit_count_a, 0);
        check("clr_hit_count_b", hit_count_b, 0);
        check("clr_last_hit", last_hit_a, 1'b0);
        repeat (10) @(posedge CLOCK_50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
